serial_pattern_tx: RTL and testbench

Transmit side of the serial "01"-framed bit line that the team's zero/one sequence detector consumes.
- Accepts a parallel WIDTH-bit word through a valid/ready handshake.
- Drives it out on a single serial line: a "0 then 1" sync pair, then the data MSB-first, then a high guard gap.
- The line idles high, so a downstream 0→1 detector locks on the sync pair.
- Used by the traffic-light simulator to send phase/command codes between controller blocks.

---
 rtl/serial_pattern_tx.sv | 148 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// -----------------
// Transmit side of the "01"-framed serial bit line. A parallel word is taken
// through a valid/ready handshake and sent on the single line A as:
//   sync 0, sync 1, WIDTH data bits MSB-first, GAP_BITS high guard bits.
// Every serial bit is held for BIT_CYCLES clock cycles. The line idles high,
// so a downstream 0->1 detector locks onto the sync pair.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   load_data  in   word to transmit, captured on accept
//   load_valid in   requester has a word
//   load_ready out  block can accept (decoded from the state register: IDLE)
//   A          out  registered serial line, idles 1
//   busy       out  registered, high for the whole frame
//   done       out  registered one-cycle pulse in the first IDLE cycle
module serial_pattern_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             A,
    output logic             busy,
    output logic             done
);

    localparam int CW   = $clog2(BIT_CYCLES + 1);
    localparam int BMAX = (WIDTH > GAP_BITS) ? WIDTH : GAP_BITS;
    localparam int BW   = $clog2(BMAX + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC0 = 3'd1,
        SYNC1 = 3'd2,
        DATA  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             a_q, a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            a_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        a_d     = 1'b1;
        busy_d  = 1'b0;

        // Last cycle of the current serial bit.
        bit_end = (cyc_q == CYC_LAST);

        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SYNC0;
                    shift_d = load_data;
                    cyc_d   = '0;
                end
            end
            SYNC0: begin
                if (bit_end) state_d = SYNC1;
            end
            SYNC1: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q << 1;
                    if (bit_q == DATA_LAST) state_d = GAP;
                    else                    bit_d   = bit_q + 1'b1;
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The bit counter restarts in every state.
        if (state_d != state_q) bit_d = '0;

        // A and busy are registered, so they are decoded from the state being
        // entered; this puts the first sync 0 on the line right after accept.
        case (state_d)
            SYNC0:   a_d = 1'b0;
            DATA:    a_d = shift_d[WIDTH-1];
            default: a_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign load_ready = (state_q == IDLE);
    assign A          = a_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

    localparam int W = 8;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;

    // Instance 0: BIT_CYCLES=1, instance 1: BIT_CYCLES=3, same stimulus.
    logic rdy_1, a_1, busy_1, done_1;
    logic rdy_3, a_3, busy_3, done_3;

    serial_pattern_tx #(.WIDTH(W), .BIT_CYCLES(1), .GAP_BITS(G)) dut1 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_1), .A(a_1), .busy(busy_1), .done(done_1)
    );

    serial_pattern_tx #(.WIDTH(W), .BIT_CYCLES(3), .GAP_BITS(G)) dut3 (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy_3), .A(a_3), .busy(busy_3), .done(done_3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of line bits (0, 1, data MSB-first,
    // GAP_BITS ones), each repeated BIT_CYCLES times; the model walks through
    // it one cycle at a time.
    bit           act[2];
    int           cur[2];
    logic [W-1:0] fd[2];
    bit           ea[2];
    bit           ed[2];
    bit           prev_a[2];

    function automatic int bcyc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int flen(input int b);
        return (2 + W + G) * b;
    endfunction

    function automatic bit wbit(input int b, input logic [W-1:0] d, input int k);
        int j;
        j = k / b;
        if (j == 0) return 1'b0;
        if (j == 1) return 1'b1;
        if (j < 2 + W) return d[W-1-(j-2)];
        return 1'b1;
    endfunction

    task automatic step(input int i);
        bit rdy;
        int b;
        b = bcyc(i);
        if (!rst) begin
            act[i] = 1'b0;
            ea[i]  = 1'b1;
            ed[i]  = 1'b0;
            return;
        end
        rdy   = !act[i];
        ed[i] = 1'b0;
        if (act[i]) begin
            cur[i]++;
            if (cur[i] == flen(b)) begin
                act[i] = 1'b0;
                ed[i]  = 1'b1;
                ea[i]  = 1'b1;
            end else begin
                ea[i] = wbit(b, fd[i], cur[i]);
            end
        end
        if (rdy && load_valid) begin
            act[i] = 1'b1;
            cur[i] = 0;
            fd[i]  = load_data;
            ea[i]  = wbit(b, load_data, 0);
            ed[i]  = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; cur[i] = 0; fd[i] = '0;
            ea[i] = 1'b1; ed[i] = 1'b0; prev_a[i] = 1'b1;
        end
    end

    always @(posedge clk) begin
        step(0);
        step(1);
        #1;
        for (int i = 0; i < 2; i++) begin
            logic ga, gb, gd, gr;
            string n;
            n  = (i == 0) ? "b1" : "b3";
            ga = (i == 0) ? a_1    : a_3;
            gb = (i == 0) ? busy_1 : busy_3;
            gd = (i == 0) ? done_1 : done_3;
            gr = (i == 0) ? rdy_1  : rdy_3;
            check({n, "_A"},     32'(ga), 32'(ea[i]));
            check({n, "_busy"},  32'(gb), 32'(act[i]));
            check({n, "_done"},  32'(gd), 32'(ed[i]));
            check({n, "_ready"}, 32'(gr), 32'(!act[i]));
            // Simple 0->1 detector on the line must fire entering sync 1.
            if (act[i] && cur[i] == bcyc(i))
                check({n, "_det"}, 32'(!prev_a[i] && ga), 32'd1);
            prev_a[i] = ga;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        // Asynchronous reset at start.
        #1 rst = 1'b0;
        #1;
        check("rst_A1", 32'(a_1), 32'd1);
        check("rst_busy1", 32'(busy_1), 32'd0);
        check("rst_done1", 32'(done_1), 32'd0);
        check("rst_ready1", 32'(rdy_1), 32'd1);
        check("rst_A3", 32'(a_3), 32'd1);
        check("rst_ready3", 32'(rdy_3), 32'd1);
        cycles(3);
        rst = 1'b1;
        cycles(2);

        // Single frame 0xA5.
        send(8'hA5);
        cycles(45);

        // valid held high: back-to-back frames, data changed after accept.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h0F;
        @(negedge clk);
        load_data  = 8'hF0;
        cycles(40);
        load_valid = 1'b0;
        cycles(45);

        // 0x00 with ignored pulses of 0xFF while busy.
        send(8'h00);
        cycles(2);
        load_valid = 1'b1; load_data = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0; load_data = 8'h00;
        cycles(3);
        load_valid = 1'b1; load_data = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0;
        cycles(45);

        // Stretched-bit frame 0x80.
        send(8'h80);
        cycles(45);

        // Reset mid-frame, between clock edges.
        send(8'hA5);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("mid_A1", 32'(a_1), 32'd1);
        check("mid_busy1", 32'(busy_1), 32'd0);
        check("mid_done1", 32'(done_1), 32'd0);
        check("mid_ready1", 32'(rdy_1), 32'd1);
        check("mid_A3", 32'(a_3), 32'd1);
        check("mid_busy3", 32'(busy_3), 32'd0);
        cycles(2);
        rst = 1'b1;
        cycles(2);
        send(8'h3C);
        cycles(45);

        // Randomised traffic with rare resets.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = W'($urandom);
            rst        = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst = 1'b1;
        load_valid = 1'b0;
        cycles(45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
